// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial sequence detector.
// kmp_next turns a pattern into the detector's next-state table at compile time.
package seq_det_pkg;

    localparam int                     DEF_SEQ_LEN = 4;
    localparam logic [DEF_SEQ_LEN-1:0] DEF_PATTERN = 4'b1010;
    localparam int                     MAX_SEQ_LEN = 16;

    function automatic int state_width(input int seq_len);
        return $clog2(seq_len + 1);
    endfunction

    // Bit i of the pattern in arrival order (i=0 is the first bit received).
    function automatic logic pat_bit(input logic [MAX_SEQ_LEN-1:0] pat, input int len, input int i);
        logic [MAX_SEQ_LEN-1:0] sh;
        sh = pat >> (len - 1 - i);
        return sh[0];
    endfunction

    // Longest pattern prefix that is a suffix of (first k pattern bits, b).
    function automatic int kmp_next(input logic [MAX_SEQ_LEN-1:0] pat, input int len,
                                    input int k, input logic b);
        int   best;
        int   idx;
        logic ok;
        logic sb;
        best = 0;
        for (int j = 1; j <= MAX_SEQ_LEN; j++) begin
            if (j <= len && j <= k + 1) begin
                ok = 1'b1;
                for (int t = 0; t < MAX_SEQ_LEN; t++) begin
                    if (t < j) begin
                        idx = k + 1 - j + t;
                        sb  = (idx == k) ? b : pat_bit(pat, len, idx);
                        if (sb != pat_bit(pat, len, t)) ok = 1'b0;
                    end
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; reset and clear both force zero and beat an increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && cnt != '1) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/moore_seq_det.sv
// Moore serial sequence detector: state is the matched-prefix length, y flags the
// full-match state, and a saturating counter tallies entries into that state.
module moore_seq_det
    import seq_det_pkg::*;
#(
    parameter int                 SEQ_LEN = DEF_SEQ_LEN,
    parameter logic [SEQ_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            x,
    input  logic                            clr_cnt,
    output logic                            y,
    output logic [state_width(SEQ_LEN)-1:0] state_o,
    output logic [CNT_W-1:0]                match_cnt
);

    localparam int            SW      = state_width(SEQ_LEN);
    localparam logic [SW-1:0] S_MATCH = SW'(SEQ_LEN);

    logic [SW-1:0] nxt_tbl [SEQ_LEN+1][2];
    logic [SW-1:0] state;
    logic [SW-1:0] nxt;

    // Non-overlapping mode leaves the match state as though starting from S_0.
    for (genvar k = 0; k <= SEQ_LEN; k++) begin : g_row
        localparam int FROM = (k == SEQ_LEN && !OVERLAP) ? 0 : k;
        assign nxt_tbl[k][0] = SW'(kmp_next(16'(PATTERN), SEQ_LEN, FROM, 1'b0));
        assign nxt_tbl[k][1] = SW'(kmp_next(16'(PATTERN), SEQ_LEN, FROM, 1'b1));
    end

    // Unused encodings fall back to S_0.
    always_comb begin
        nxt = '0;
        for (int k = 0; k <= SEQ_LEN; k++) begin
            if (state == SW'(k)) nxt = x ? nxt_tbl[k][1] : nxt_tbl[k][0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
            y     <= 1'b0;
        end else if (en) begin
            state <= nxt;
            y     <= (nxt == S_MATCH);
        end
    end

    assign state_o = state;

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (en && (nxt == S_MATCH)),
        .cnt (match_cnt)
    );

endmodule

// File: tb/tb_moore_seq_det.sv
// Bench for moore_seq_det: five parameter sets share one stimulus stream and are
// compared every cycle against a brute-force string-matching model.
module tb_moore_seq_det;

    localparam int NCFG = 5;
    localparam int          CFG_LEN [NCFG] = '{4, 4, 4, 4, 6};
    localparam logic [15:0] CFG_PAT [NCFG] = '{16'hA, 16'hA, 16'hF, 16'hA, 16'b110110};
    localparam bit          CFG_OV  [NCFG] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam int          CFG_MAX [NCFG] = '{255, 255, 255, 3, 255};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic x = 1'b0;
    logic clr_cnt = 1'b0;

    logic       y_v   [NCFG];
    logic [2:0] st_v  [NCFG];
    logic [7:0] cnt_v [NCFG];
    logic [1:0] cnt3;

    int checks = 0;
    int errors = 0;

    // model state
    logic [31:0] m_hist [NCFG];
    int          m_hlen [NCFG];
    int          m_st   [NCFG];
    int          m_cnt  [NCFG];
    bit          model_valid = 1'b0;

    always #5 clk = ~clk;

    moore_seq_det #(.SEQ_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(8)) u_d0 (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
        .y(y_v[0]), .state_o(st_v[0]), .match_cnt(cnt_v[0]));
    moore_seq_det #(.SEQ_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(8)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
        .y(y_v[1]), .state_o(st_v[1]), .match_cnt(cnt_v[1]));
    moore_seq_det #(.SEQ_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(8)) u_d2 (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
        .y(y_v[2]), .state_o(st_v[2]), .match_cnt(cnt_v[2]));
    moore_seq_det #(.SEQ_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(2)) u_d3 (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
        .y(y_v[3]), .state_o(st_v[3]), .match_cnt(cnt3));
    moore_seq_det #(.SEQ_LEN(6), .PATTERN(6'b110110), .OVERLAP(1'b1), .CNT_W(8)) u_d4 (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
        .y(y_v[4]), .state_o(st_v[4]), .match_cnt(cnt_v[4]));

    assign cnt_v[3] = {6'b0, cnt3};

    // Longest k<=len such that the last k accepted bits equal the first k pattern bits.
    function automatic int longest(input logic [31:0] hist, input int hlen,
                                   input logic [15:0] pat, input int len);
        logic [31:0] mask;
        logic [31:0] pre;
        for (int k = len; k >= 1; k--) begin
            mask = (32'd1 << k) - 32'd1;
            pre  = {16'b0, pat} >> (len - k);
            if (k <= hlen && ((hist & mask) == (pre & mask))) return k;
        end
        return 0;
    endfunction

    task automatic model_step(input int i);
        if (rst) begin
            m_hist[i] = '0;
            m_hlen[i] = 0;
            m_st[i]   = 0;
            m_cnt[i]  = 0;
        end else begin
            if (en) begin
                m_hist[i] = {m_hist[i][30:0], x};
                m_hlen[i] = (m_hlen[i] < 32) ? m_hlen[i] + 1 : 32;
                m_st[i]   = longest(m_hist[i], m_hlen[i], CFG_PAT[i], CFG_LEN[i]);
                if (m_st[i] == CFG_LEN[i] && !CFG_OV[i]) begin
                    m_hist[i] = '0;
                    m_hlen[i] = 0;
                end
            end
            if (clr_cnt) m_cnt[i] = 0;
            else if (en && m_st[i] == CFG_LEN[i] && m_cnt[i] < CFG_MAX[i]) m_cnt[i] = m_cnt[i] + 1;
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < NCFG; i++) model_step(i);
        if (rst) model_valid = 1'b1;
    end

    task automatic chk(input string name, input int cfg, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cfg%0d t=%0t got %0d expected %0d", name, cfg, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < NCFG; i++) begin
                chk("y", i, int'(y_v[i]), (m_st[i] == CFG_LEN[i]) ? 1 : 0);
                chk("state_o", i, int'(st_v[i]), m_st[i]);
                chk("match_cnt", i, int'(cnt_v[i]), m_cnt[i]);
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic b, input logic c);
        @(negedge clk);
        rst = r; en = e; x = b; clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic feed(input logic b);
        step(1'b0, 1'b1, b, 1'b0);
    endtask

    initial begin
        logic [7:0] s8;
        // Overlapping 1010
        do_reset();
        chk("lit_rst_y", 0, int'(y_v[0]), 0);
        chk("lit_rst_state", 0, int'(st_v[0]), 0);
        chk("lit_rst_cnt", 0, int'(cnt_v[0]), 0);
        s8 = 8'b10101010;
        for (int i = 0; i < 6; i++) begin
            feed(s8[7-i]);
            chk("lit_ov_y", 0, int'(y_v[0]), (i == 3 || i == 5) ? 1 : 0);
        end
        chk("lit_ov_cnt", 0, int'(cnt_v[0]), 2);

        // Non-overlapping 1010 over 8 bits
        do_reset();
        for (int i = 0; i < 8; i++) begin
            feed(s8[7-i]);
            chk("lit_nov_y", 1, int'(y_v[1]), (i == 3 || i == 7) ? 1 : 0);
        end
        chk("lit_nov_cnt", 1, int'(cnt_v[1]), 2);

        // 1111 overlapping: consecutive matches
        do_reset();
        for (int i = 0; i < 6; i++) begin
            feed(1'b1);
            chk("lit_ones_y", 2, int'(y_v[2]), (i >= 3) ? 1 : 0);
        end
        chk("lit_ones_cnt", 2, int'(cnt_v[2]), 3);

        // Mid-sequence reset discards 1,0,1
        do_reset();
        feed(1'b1); feed(1'b0); feed(1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("lit_midrst_state", 0, int'(st_v[0]), 0);
        s8 = 8'b01010000;
        for (int i = 0; i < 5; i++) begin
            feed(s8[7-i]);
            chk("lit_midrst_y", 0, int'(y_v[0]), (i == 4) ? 1 : 0);
        end
        chk("lit_midrst_cnt", 0, int'(cnt_v[0]), 1);

        // Enable stall holds S_2
        do_reset();
        feed(1'b1); feed(1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, i[0] ? 1'b0 : 1'b1, 1'b0);
            chk("lit_stall_state", 0, int'(st_v[0]), 2);
            chk("lit_stall_y", 0, int'(y_v[0]), 0);
        end
        feed(1'b1);
        chk("lit_stall_y", 0, int'(y_v[0]), 0);
        feed(1'b0);
        chk("lit_stall_y", 0, int'(y_v[0]), 1);
        chk("lit_stall_cnt", 0, int'(cnt_v[0]), 1);

        // CNT_W=2 saturation and clear-wins
        do_reset();
        feed(1'b1); feed(1'b0);
        for (int i = 0; i < 5; i++) begin
            feed(1'b1); feed(1'b0);
        end
        chk("lit_sat_cnt", 3, int'(cnt_v[3]), 3);
        feed(1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("lit_clr_cnt", 3, int'(cnt_v[3]), 0);
        chk("lit_clr_y", 3, int'(y_v[3]), 1);

        // Randomized phase
        for (int n = 0; n < 4000; n++) begin
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
